cpu_mem_xfer: RTL and testbench

Multi-cycle transfer sequencer for the CHIP-8 memory/register instructions FX55 (store V0..VX), FX65 (load V0..VX) and FX33 (BCD of VX).
- Sits beside the `cpu_registers` file: drives its `x`/`wx`/`nx` port and reads back `Vx`.
- On the other side it drives the main RAM port.
- Decode pulses `start`, stalls while `busy`, and resumes on `done`.

---
 rtl/cpu_mem_xfer.sv | 190 +++++++++++++++++++
 tb/tb_cpu_mem_xfer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_xfer.sv
// CHIP-8 FX55/FX65/FX33 transfer sequencer between register file and RAM.
// Optional macro CHIP8_I_INCREMENT_EN: store/load advance I by X+1 on completion.
`timescale 1ns/1ps
module cpu_mem_xfer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [3:0]  x_last,
    input  logic [11:0] i_addr,
    output logic        busy,
    output logic        done,
    output logic [3:0]  reg_sel,
    input  logic [7:0]  reg_rdata,
    output logic        reg_we,
    output logic [7:0]  reg_wdata,
    output logic [11:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        i_we,
    output logic [11:0] i_next
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_LOAD_REQ,
        S_LOAD_WB,
        S_BCD_LATCH,
        S_BCD_WR,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  x_q, x_d;
    logic [3:0]  k_q, k_d;
    logic [11:0] i_q, i_d;
    logic [7:0]  v_q, v_d;
    logic [11:0] addr;
    logic [7:0]  digit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= 4'd0;
            k_q     <= 4'd0;
            i_q     <= 12'd0;
            v_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            k_q     <= k_d;
            i_q     <= i_d;
            v_q     <= v_d;
        end
    end

`ifdef CHIP8_I_INCREMENT_EN
    logic inc_q, inc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_q <= 1'b0;
        end else begin
            inc_q <= inc_d;
        end
    end

    always_comb begin
        inc_d = inc_q;
        if (state_q == S_IDLE && start) begin
            inc_d = ~op[1];
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        k_d     = k_q;
        i_d     = i_q;
        v_d     = v_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d = x_last;
                    i_d = i_addr;
                    k_d = 4'd0;
                    unique case (op)
                        2'b00:   state_d = S_STORE;
                        2'b01:   state_d = S_LOAD_REQ;
                        2'b10:   state_d = S_BCD_LATCH;
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_STORE: begin
                if (k_q == x_q) state_d = S_DONE;
                else            k_d = k_q + 4'd1;
            end
            S_LOAD_REQ: state_d = S_LOAD_WB;
            S_LOAD_WB: begin
                if (k_q == x_q) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + 4'd1;
                    state_d = S_LOAD_REQ;
                end
            end
            S_BCD_LATCH: begin
                v_d     = reg_rdata;
                k_d     = 4'd0;
                state_d = S_BCD_WR;
            end
            S_BCD_WR: begin
                if (k_q == 4'd2) state_d = S_DONE;
                else             k_d = k_q + 4'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign addr = i_q + {8'd0, k_q};

    // k doubles as the digit index j while in BCD_WR
    always_comb begin
        unique case (k_q[1:0])
            2'd0:    digit = v_q / 8'd100;
            2'd1:    digit = (v_q / 8'd10) % 8'd10;
            default: digit = v_q % 8'd10;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        reg_sel   = 4'd0;
        reg_we    = 1'b0;
        reg_wdata = 8'd0;
        mem_addr  = 12'd0;
        mem_we    = 1'b0;
        mem_wdata = 8'd0;
        i_we      = 1'b0;
        i_next    = 12'd0;
        unique case (state_q)
            S_IDLE: ;
            S_STORE: begin
                busy      = 1'b1;
                reg_sel   = k_q;
                mem_addr  = addr;
                mem_we    = 1'b1;
                mem_wdata = reg_rdata;
            end
            S_LOAD_REQ: begin
                busy     = 1'b1;
                mem_addr = addr;
            end
            S_LOAD_WB: begin
                busy      = 1'b1;
                reg_sel   = k_q;
                reg_we    = 1'b1;
                reg_wdata = mem_rdata;
            end
            S_BCD_LATCH: begin
                busy    = 1'b1;
                reg_sel = x_q;
            end
            S_BCD_WR: begin
                busy      = 1'b1;
                mem_addr  = addr;
                mem_we    = 1'b1;
                mem_wdata = digit;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
`ifdef CHIP8_I_INCREMENT_EN
                if (inc_q) begin
                    i_we   = 1'b1;
                    i_next = i_q + {8'd0, x_q} + 12'd1;
                end
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_mem_xfer.sv
// Scoreboard bench for cpu_mem_xfer with register-file and RAM models.
// Honours CHIP8_I_INCREMENT_EN when defined for the build.
`timescale 1ns/1ps
module tb_cpu_mem_xfer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [3:0]  x_last = 4'd0;
    logic [11:0] i_addr = 12'd0;
    logic        busy, done, reg_we, mem_we, i_we;
    logic [3:0]  reg_sel;
    logic [7:0]  reg_rdata, reg_wdata, mem_wdata;
    logic [7:0]  mem_rdata;
    logic [11:0] mem_addr, i_next;

    cpu_mem_xfer dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .x_last(x_last), .i_addr(i_addr), .busy(busy), .done(done),
        .reg_sel(reg_sel), .reg_rdata(reg_rdata), .reg_we(reg_we),
        .reg_wdata(reg_wdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .i_we(i_we),
        .i_next(i_next)
    );

    always #5 clk = ~clk;

    // environment: register file and synchronous-read RAM
    logic [7:0]  env_ram [4096];
    logic [7:0]  env_reg [16];
    logic        pk_en = 1'b0;
    logic        pk_reg = 1'b0;
    logic [11:0] pk_a = 12'd0;
    logic [7:0]  pk_d = 8'd0;

    always @(posedge clk) begin
        mem_rdata <= env_ram[mem_addr];
        if (mem_we) env_ram[mem_addr] <= mem_wdata;
        if (reg_we) env_reg[reg_sel] <= reg_wdata;
        if (pk_en) begin
            if (pk_reg) env_reg[pk_a[3:0]] <= pk_d;
            else        env_ram[pk_a] <= pk_d;
        end
    end

    assign reg_rdata = env_reg[reg_sel];

    // reference state
    logic [7:0] m_ram [4096];
    logic [7:0] m_reg [16];

    typedef struct {
        int kind;
        int cyc;
        int a;
        int d;
        int iwe;
        int inx;
    } ev_t;

    ev_t q[$];
    int  edge_cnt = 0;
    int  b_lo = 0;
    int  b_hi = -1;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // monitor
    always @(negedge clk) begin : mon
        ev_t e;
        int  kd;
        if (!rst) begin
            chk("busy", {63'd0, busy},
                {63'd0, (edge_cnt >= b_lo && edge_cnt <= b_hi)});
            if (mem_we && reg_we) chk("we_overlap", 64'd1, 64'd0);
            if (i_we && !done) chk("i_we_outside_done", 64'd1, 64'd0);
            if (mem_we || reg_we || done) begin
                kd = mem_we ? 0 : (reg_we ? 1 : 2);
                if (q.size() == 0) begin
                    chk("unexpected_event", {61'd0, mem_we, reg_we, done},
                        64'd0);
                end else begin
                    e = q.pop_front();
                    chk("ev_kind", kd, e.kind);
                    chk("ev_cycle", edge_cnt, e.cyc);
                    if (kd == 0) begin
                        chk("mem_addr", {52'd0, mem_addr}, e.a);
                        chk("mem_wdata", {56'd0, mem_wdata}, e.d);
                    end else if (kd == 1) begin
                        chk("reg_sel", {60'd0, reg_sel}, e.a);
                        chk("reg_wdata", {56'd0, reg_wdata}, e.d);
                    end else begin
                        chk("done_busy", {63'd0, busy}, 64'd1);
                        chk("i_we", {63'd0, i_we}, e.iwe);
                        chk("i_next", {52'd0, i_next}, e.inx);
                    end
                end
            end
        end
    end

    function automatic logic [63:0] all_outs();
        return {15'd0, busy, done, reg_we, mem_we, i_we, reg_sel,
                reg_wdata, mem_addr, mem_wdata, i_next};
    endfunction

    task automatic poke(input bit is_reg, input int a, input int d);
        @(negedge clk);
        pk_en  = 1'b1;
        pk_reg = is_reg;
        pk_a   = a[11:0];
        pk_d   = d[7:0];
        if (is_reg) m_reg[a[3:0]] = d[7:0];
        else        m_ram[a[11:0]] = d[7:0];
        @(posedge clk);
        #1 pk_en = 1'b0;
    endtask

    task automatic launch(input int o, input int x, input int i,
                          input bit rst_mid);
        int s, len, a, v, iwe, inx;
        int dg [3];
        @(negedge clk);
        start  = 1'b1;
        op     = o[1:0];
        x_last = x[3:0];
        i_addr = i[11:0];
        @(posedge clk);
        #1;
        s     = edge_cnt;
        start = 1'b0;
        case (o)
            0:       len = x + 2;
            1:       len = 2 * x + 3;
            2:       len = 5;
            default: len = 1;
        endcase
        b_lo = s;
        b_hi = s + len - 1;
        if (o == 0) begin
            for (int k = 0; k <= x; k++) begin
                a = (i + k) % 4096;
                q.push_back('{0, s + k, a, int'(m_reg[k]), 0, 0});
                m_ram[a] = m_reg[k];
            end
        end else if (o == 1) begin
            for (int k = 0; k <= x; k++) begin
                if (!(rst_mid && k > 0)) begin
                    a = (i + k) % 4096;
                    q.push_back('{1, s + 2 * k + 1, k, int'(m_ram[a]), 0, 0});
                    m_reg[k] = m_ram[a];
                end
            end
        end else if (o == 2) begin
            v = int'(m_reg[x]);
            dg[0] = v / 100;
            dg[1] = (v / 10) % 10;
            dg[2] = v % 10;
            for (int j = 0; j < 3; j++) begin
                a = (i + j) % 4096;
                q.push_back('{0, s + 1 + j, a, dg[j], 0, 0});
                m_ram[a] = dg[j][7:0];
            end
        end
`ifdef CHIP8_I_INCREMENT_EN
        iwe = (o < 2) ? 1 : 0;
`else
        iwe = 0;
`endif
        inx = iwe ? (i + x + 1) % 4096 : 0;
        if (!rst_mid) q.push_back('{2, s + len - 1, 0, 0, iwe, inx});
    endtask

    task automatic finish_op(input string nm);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk({nm, "_pending"}, q.size(), 64'd0);
        q.delete();
        repeat (3) @(negedge clk);
        #1 chk({nm, "_idle_outs"}, all_outs(), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset_outs", all_outs(), 64'd0);
        for (int a = 0; a < 4096; a++) poke(1'b0, a, int'($urandom_range(0, 255)));
        for (int r = 0; r < 16; r++) poke(1'b1, r, int'($urandom_range(0, 255)));
        chk("reset_hold_outs", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        poke(1'b1, 0, 8'h11);
        poke(1'b1, 1, 8'h22);
        poke(1'b1, 2, 8'h33);
        poke(1'b1, 3, 8'h44);
        launch(0, 3, 12'h300, 1'b0);
        finish_op("store");
        chk("store_v4_untouched", env_ram[12'h304], m_ram[12'h304]);

        poke(1'b0, 12'h200, 8'hA0);
        poke(1'b0, 12'h201, 8'hB1);
        poke(1'b0, 12'h202, 8'hC2);
        launch(1, 2, 12'h200, 1'b0);
        finish_op("load");
        chk("load_v1", env_reg[1], 8'hB1);
        chk("load_v3_unchanged", env_reg[3], m_reg[3]);

        poke(1'b1, 5, 8'hFE);
        launch(2, 5, 12'h400, 1'b0);
        finish_op("bcd254");
        poke(1'b1, 6, 8'h07);
        launch(2, 6, 12'h410, 1'b0);
        finish_op("bcd7");

        launch(0, 2, 12'hFFE, 1'b0);
        finish_op("wrap");
        chk("wrap_ram0", env_ram[0], m_reg[2]);

        launch(1, 5, 12'h500, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        b_hi = -1;
        #1 chk("rst_mid_outs", all_outs(), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        finish_op("rst_mid");
        chk("rst_mid_v1", env_reg[1], m_reg[1]);
        launch(1, 5, 12'h500, 1'b0);
        finish_op("after_rst");

        launch(0, 3, 12'h600, 1'b0);
        @(negedge clk);
        start  = 1'b1;
        op     = 2'd1;
        x_last = 4'd7;
        @(negedge clk);
        start  = 1'b0;
        finish_op("busy_start");

        launch(0, 1, 12'h610, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        op    = 2'd3;
        @(posedge clk);
        #1 start = 1'b0;
        finish_op("done_start");

        launch(3, 4, 12'h123, 1'b0);
        finish_op("reserved");

        for (int n = 0; n < 40; n++) begin
            launch(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 4095)), 1'b0);
            finish_op("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
